// File: rtl/sram_1r1w_arb.sv
// Front-end for a simple dual-port SRAM: zero sweep after reset/on demand,
// round-robin sharing of the write port, read pass-through with a valid pipeline.
//
//   state | meaning
//   CLEAR | sweeping zeros into every word, requests held off
//   RUN   | arbitrating writes, accepting reads
module sram_1r1w_arb #(
    parameter int WID = 512,
    parameter int DEP = 256,
    parameter int RL  = 1,
    parameter int NW  = 2,
    parameter int AW  = $clog2(DEP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic [NW-1:0]     wreq,
    input  logic [NW*AW-1:0]  wadr_in,
    input  logic [NW*WID-1:0] wdat_in,
    output logic [NW-1:0]     wack,
    input  logic              rreq,
    input  logic [AW-1:0]     radr_in,
    output logic              rack,
    output logic              rvalid,
    output logic [WID-1:0]    rdat,
    output logic              sram_wr,
    output logic [AW-1:0]     sram_wadr,
    output logic [WID-1:0]    sram_i,
    output logic [AW-1:0]     sram_radr,
    input  logic [WID-1:0]    sram_o
);

    localparam int PW = $clog2(NW);
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEP - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW:0]   cnt, cnt_nxt;
    logic [PW-1:0] rr_ptr, gnt_idx;
    logic          gnt_vld;
    logic [RL-1:0] vp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                if (clr_req) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + (AW+1)'(1);
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        if (state == RUN && !clr_req) begin
            for (int i = 1; i <= NW; i++) begin
                if (!gnt_vld && wreq[(int'(rr_ptr) + i) % NW]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'((int'(rr_ptr) + i) % NW);
                end
            end
        end
    end

    always_comb begin
        wack = '0;
        if (gnt_vld) wack[gnt_idx] = 1'b1;
    end

    assign busy      = (state == CLEAR);
    assign rack      = (state == RUN) && rreq && !clr_req;
    assign sram_radr = radr_in;
    assign rdat      = sram_o;
    assign rvalid    = vp[RL-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_wr   <= 1'b0;
            sram_wadr <= '0;
            sram_i    <= '0;
            rr_ptr    <= PW'(NW - 1);
        end else if (state == CLEAR) begin
            sram_wr   <= 1'b1;
            sram_wadr <= cnt[AW-1:0];
            sram_i    <= '0;
        end else if (gnt_vld) begin
            sram_wr   <= 1'b1;
            sram_wadr <= wadr_in[int'(gnt_idx)*AW +: AW];
            sram_i    <= wdat_in[int'(gnt_idx)*WID +: WID];
            rr_ptr    <= gnt_idx;
        end else begin
            sram_wr   <= 1'b0;
        end
    end

    if (RL == 1) begin : g_vp1
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) vp <= '0;
            else      vp <= rack;
        end
    end else begin : g_vpn
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) vp <= '0;
            else      vp <= {vp[RL-2:0], rack};
        end
    end

endmodule

// File: tb/tb_sram_1r1w_arb.sv
// Two arbiter instances (read latency 1 and 2) on shared stimulus, each with a
// behavioural SRAM, checked against an array/ring reference of the arbiter's rules.
module tb_sram_1r1w_arb;

    localparam int WID = 16;
    localparam int DEP = 16;
    localparam int NW  = 2;
    localparam int AW  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clr_req = 1'b0;
    logic [NW-1:0]     wreq = '0;
    logic [NW*AW-1:0]  wadr_in = '0;
    logic [NW*WID-1:0] wdat_in = '0;
    logic              rreq = 1'b0;
    logic [AW-1:0]     radr_in = '0;

    logic              busy1, rack1, rvalid1, sram_wr1;
    logic [NW-1:0]     wack1;
    logic [WID-1:0]    rdat1, sram_i1, sram_o1;
    logic [AW-1:0]     sram_wadr1, sram_radr1;
    logic              busy2, rack2, rvalid2, sram_wr2;
    logic [NW-1:0]     wack2;
    logic [WID-1:0]    rdat2, sram_i2, sram_o2, pipe2;
    logic [AW-1:0]     sram_wadr2, sram_radr2;

    logic [WID-1:0]    mem1 [DEP];
    logic [WID-1:0]    mem2 [DEP];

    always #5 clk = ~clk;

    sram_1r1w_arb #(.WID(WID), .DEP(DEP), .RL(1), .NW(NW)) dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .wreq(wreq), .wadr_in(wadr_in), .wdat_in(wdat_in), .wack(wack1),
        .rreq(rreq), .radr_in(radr_in), .rack(rack1), .rvalid(rvalid1), .rdat(rdat1),
        .sram_wr(sram_wr1), .sram_wadr(sram_wadr1), .sram_i(sram_i1),
        .sram_radr(sram_radr1), .sram_o(sram_o1));

    sram_1r1w_arb #(.WID(WID), .DEP(DEP), .RL(2), .NW(NW)) dut2 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2),
        .wreq(wreq), .wadr_in(wadr_in), .wdat_in(wdat_in), .wack(wack2),
        .rreq(rreq), .radr_in(radr_in), .rack(rack2), .rvalid(rvalid2), .rdat(rdat2),
        .sram_wr(sram_wr2), .sram_wadr(sram_wadr2), .sram_i(sram_i2),
        .sram_radr(sram_radr2), .sram_o(sram_o2));

    // behavioural SRAMs with same-address write bypass
    always @(posedge clk) begin
        if (sram_wr1) mem1[sram_wadr1] <= sram_i1;
        sram_o1 <= (sram_wr1 && sram_wadr1 == sram_radr1) ? sram_i1 : mem1[sram_radr1];
        if (sram_wr2) mem2[sram_wadr2] <= sram_i2;
        pipe2   <= (sram_wr2 && sram_wadr2 == sram_radr2) ? sram_i2 : mem2[sram_radr2];
        sram_o2 <= pipe2;
    end

    int             total = 0;
    int             bad = 0;
    int             cyc;
    int             m_busy;
    int             m_last;
    int             last_g;
    logic           m_wr;
    logic [AW-1:0]  m_wadr;
    logic [WID-1:0] m_wdat;
    logic [WID-1:0] ref_mem [DEP];
    logic           rv_ring [64];
    logic [WID-1:0] rd_ring [64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = DEP;
        m_last = NW - 1;
        m_wr   = 1'b0;
        m_wadr = '0;
        m_wdat = '0;
        last_g = -1;
        cyc    = 0;
        for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
        for (int i = 0; i < 64; i++) begin
            rv_ring[i] = 1'b0;
            rd_ring[i] = '0;
        end
    endtask

    task automatic step();
        int             g;
        logic           eb, er;
        logic [NW-1:0]  ew;
        int             i1, i2;
        @(negedge clk);
        eb = (m_busy > 0);
        g  = -1;
        if (!eb && !clr_req) begin
            for (int i = 1; i <= NW; i++) begin
                if (g < 0 && wreq[(m_last + i) % NW]) g = (m_last + i) % NW;
            end
        end
        ew = '0;
        if (g >= 0) ew[g] = 1'b1;
        er = rreq && !clr_req && !eb;

        chk("busy1", busy1, eb);
        chk("busy2", busy2, eb);
        chk("wack1", wack1, ew);
        chk("wack2", wack2, ew);
        chk("rack1", rack1, er);
        chk("rack2", rack2, er);
        chk("radr1", sram_radr1, radr_in);
        chk("radr2", sram_radr2, radr_in);
        chk("wr1", sram_wr1, m_wr);
        chk("wr2", sram_wr2, m_wr);
        if (m_wr) begin
            chk("wadr1", sram_wadr1, m_wadr);
            chk("wadr2", sram_wadr2, m_wadr);
            chk("wdat1", sram_i1, m_wdat);
            chk("wdat2", sram_i2, m_wdat);
        end
        i1 = (cyc - 1) & 63;
        i2 = (cyc - 2) & 63;
        chk("rvalid1", rvalid1, rv_ring[i1]);
        if (rv_ring[i1]) chk("rdat1", rdat1, rd_ring[i1]);
        chk("rvalid2", rvalid2, rv_ring[i2]);
        if (rv_ring[i2]) chk("rdat2", rdat2, rd_ring[i2]);

        rv_ring[cyc & 63] = er;
        rd_ring[cyc & 63] = ref_mem[radr_in];

        if (eb) begin
            m_wr   = 1'b1;
            m_wadr = AW'(DEP - m_busy);
            m_wdat = '0;
            m_busy = clr_req ? DEP : m_busy - 1;
        end else if (clr_req) begin
            m_wr   = 1'b0;
            m_busy = DEP;
            for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
        end else if (g >= 0) begin
            m_wr   = 1'b1;
            m_wadr = wadr_in[g*AW +: AW];
            m_wdat = wdat_in[g*WID +: WID];
            ref_mem[m_wadr] = m_wdat;
            m_last = g;
        end else begin
            m_wr = 1'b0;
        end
        cyc++;
        last_g = g;
        @(posedge clk);
        #1;
        if (g >= 0) wreq[g] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [WID-1:0] d);
        wreq[k] = 1'b1;
        wadr_in[k*AW +: AW]   = a;
        wdat_in[k*WID +: WID] = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset(3);
        chk("rst_wr_initial", sram_wr1, 1'b0);

        // sweep, then read back every address
        repeat (DEP + 1) step();
        for (int a = 0; a < DEP; a++) begin
            rreq = 1'b1;
            radr_in = AW'(a);
            step();
        end
        rreq = 1'b0;
        repeat (3) step();

        // both requesters held: alternate grants
        for (int n = 0; n < 4; n++) begin
            set_req(0, 4'd3, 16'h1000 + 16'(n));
            set_req(1, 4'd7, 16'h2000 + 16'(n));
            step();
        end
        wreq = '0;
        step();

        // write then read back at latency 1 and 2
        set_req(0, 4'd5, 16'h00AB);
        step();
        repeat (2) step();
        rreq = 1'b1;
        radr_in = 4'd5;
        step();
        rreq = 1'b0;
        repeat (3) step();

        // read in flight, then clear while a write waits
        rreq = 1'b1;
        radr_in = 4'd5;
        step();
        rreq = 1'b0;
        clr_req = 1'b1;
        set_req(0, 4'd9, 16'h5A5A);
        step();
        clr_req = 1'b0;
        repeat (DEP + 2) step();
        wreq = '0;

        // restart mid-sweep
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (DEP + 2) step();

        // async reset mid-sweep and mid-read
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (7) step();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_wr1", sram_wr1, 1'b0);
        chk("async_rst_busy1", busy1, 1'b1);
        chk("async_rst_wr2", sram_wr2, 1'b0);
        do_reset(2);
        repeat (DEP + 2) step();
        rreq = 1'b1;
        radr_in = 4'd1;
        step();
        rreq = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_rvalid2", rvalid2, 1'b0);
        do_reset(2);
        repeat (DEP + 2) step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NW; k++) begin
                if (!wreq[k] && ($urandom % 3) == 0)
                    set_req(k, AW'($urandom), WID'($urandom));
                else if (wreq[k] && ($urandom % 20) == 0)
                    wreq[k] = 1'b0;
            end
            rreq    = ($urandom % 2) == 0;
            radr_in = AW'($urandom);
            clr_req = ($urandom % 64) == 0;
            if (($urandom % 700) == 0) begin
                wreq = '0;
                rreq = 1'b0;
                clr_req = 1'b0;
                do_reset(2);
            end else begin
                step();
            end
        end
        clr_req = 1'b0;
        rreq = 1'b0;
        wreq = '0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
